// File: rtl/pmod_debounce_pkg.sv
// Shared state encoding, default timing and width helper for the PMOD debouncer.
package pmod_debounce_pkg;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  typedef enum logic {
    STABLE  = ST_STABLE,
    PENDING = ST_PENDING
  } chan_state_e;

  localparam int CLK_HZ      = 12000000;
  localparam int DEBOUNCE_MS = 5;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2_f(input int value);
    int bits;
    int v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pmod_debounce_chan.sv
// One PMOD channel: synchroniser, debounce FSM, edge strobes.
// Hold counter and out_long strobe only with PMOD_DEBOUNCE_LONGPRESS_EN.
module pmod_debounce_chan
  import pmod_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter logic INIT_LEVEL      = 1'b0
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
  ,
  parameter int   LONG_CYCLES     = CLK_HZ
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
  ,
  output logic long_o
`endif
);

  localparam int            CW      = clog2_f(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  chan_state_e            state_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (sync != level_q) begin
            state_q <= PENDING;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
          end else begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        PENDING: begin
          if (sync == level_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            // Strobe is registered alongside the level so both change on the same edge.
            level_q <= sync;
            rise_q  <= sync;
            fall_q  <= ~sync;
            state_q <= STABLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_d;
            busy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = busy_q;

`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
  localparam int            HW       = clog2_f(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          long_q;

  assign hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);

  // Saturation at HOLD_MAX limits the strobe to one per press.
  always_ff @(posedge clk_i) begin
    if (rst_i || !level_q) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= (hold_q != HOLD_MAX) && (hold_d == HOLD_MAX);
    end
  end

  assign long_o = long_q;
`endif

endmodule

// File: rtl/pmod_debounce.sv
// WIDTH independent debounced PMOD inputs with rise/fall strobes and a shared busy flag.
// Optional per-channel long-press strobe with PMOD_DEBOUNCE_LONGPRESS_EN.
module pmod_debounce
  import pmod_debounce_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter logic INIT_LEVEL      = 1'b0
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
  ,
  parameter int   LONG_CYCLES     = CLK_HZ
`endif
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] out_level,
  output logic [WIDTH-1:0] out_rise,
  output logic [WIDTH-1:0] out_fall,
  output logic             out_busy
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
  ,
  output logic [WIDTH-1:0] out_long
`endif
);

  logic [WIDTH-1:0] busy_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pmod_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL     (INIT_LEVEL)
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
      ,
      .LONG_CYCLES    (LONG_CYCLES)
`endif
    ) u_chan (
      .clk_i  (in_clock),
      .rst_i  (in_reset),
      .raw_i  (in_raw[i]),
      .level_o(out_level[i]),
      .rise_o (out_rise[i]),
      .fall_o (out_fall[i]),
      .busy_o (busy_w[i])
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
      ,
      .long_o (out_long[i])
`endif
    );
  end

  // Each busy bit is already registered, so the OR needs no extra flop.
  assign out_busy = |busy_w;

endmodule

// File: tb/tb_pmod_debounce.sv
// Cycle-exact vector table for the debouncer plus hand sequences for DEBOUNCE_CYCLES=1 and long-press.
module tb_pmod_debounce;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'hF;
  logic [3:0] out_level, out_rise, out_fall;
  logic       out_busy;
  logic       raw1 = 1'b0;
  logic       lvl1, rise1, fall1, busy1;
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
  logic [3:0] lng;
  logic       lng1;
`endif

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pmod_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
    , .LONG_CYCLES(8)
`endif
  ) dut (
    .in_clock(clk), .in_reset(rst), .in_raw(raw),
    .out_level(out_level), .out_rise(out_rise), .out_fall(out_fall), .out_busy(out_busy)
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
    , .out_long(lng)
`endif
  );

  pmod_debounce #(
    .WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0)
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
    , .LONG_CYCLES(8)
`endif
  ) dut1 (
    .in_clock(clk), .in_reset(rst), .in_raw(raw1),
    .out_level(lvl1), .out_rise(rise1), .out_fall(fall1), .out_busy(busy1)
`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
    , .out_long(lng1)
`endif
  );

  task automatic seg(input int n, input logic r, input logic [3:0] rw,
                     input logic [3:0] l, input logic [3:0] ri, input logic [3:0] fa,
                     input logic b);
    vec_t v;
    v.rst = r; v.raw = rw; v.lvl = l; v.rise = ri; v.fall = fa; v.busy = b;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    logic [3:0] e1 [10];
    int got;
    int at;

    // n, rst, raw, level, rise, fall, busy
    seg(3, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);   // reset with pins high
    seg(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    seg(4, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1);
    seg(1, 0, 4'hF, 4'hF, 4'hF, 4'h0, 0);
    seg(2, 0, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    seg(2, 0, 4'h0, 4'hF, 4'h0, 4'h0, 0);   // all fall together
    seg(4, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1);
    seg(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    seg(2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    seg(2, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0);   // clean step ch0
    seg(4, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1);
    seg(1, 0, 4'h1, 4'h1, 4'h1, 4'h0, 0);
    seg(2, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    seg(2, 0, 4'h3, 4'h1, 4'h0, 4'h0, 0);   // ch1 glitch of 3 cycles
    seg(1, 0, 4'h3, 4'h1, 4'h0, 4'h0, 1);
    seg(2, 0, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    seg(3, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0);
    seg(2, 0, 4'h5, 4'h1, 4'h0, 4'h0, 0);   // ch2 bounce then settle
    seg(1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    seg(1, 0, 4'h5, 4'h1, 4'h0, 4'h0, 1);
    seg(1, 0, 4'h5, 4'h1, 4'h0, 4'h0, 0);
    seg(4, 0, 4'h5, 4'h1, 4'h0, 4'h0, 1);
    seg(1, 0, 4'h5, 4'h5, 4'h4, 4'h0, 0);
    seg(2, 0, 4'h5, 4'h5, 4'h0, 4'h0, 0);
    seg(2, 0, 4'hD, 4'h5, 4'h0, 4'h0, 0);   // ch3 pending, then reset at cnt=3
    seg(3, 0, 4'hD, 4'h5, 4'h0, 4'h0, 1);
    seg(2, 1, 4'hD, 4'h0, 4'h0, 4'h0, 0);
    seg(2, 0, 4'hD, 4'h0, 4'h0, 4'h0, 0);
    seg(4, 0, 4'hD, 4'h0, 4'h0, 4'h0, 1);
    seg(1, 0, 4'hD, 4'hD, 4'hD, 4'h0, 0);
    seg(2, 0, 4'hD, 4'hD, 4'h0, 4'h0, 0);
    seg(2, 0, 4'h0, 4'hD, 4'h0, 4'h0, 0);
    seg(4, 0, 4'h0, 4'hD, 4'h0, 4'h0, 1);
    seg(1, 0, 4'h0, 4'h0, 4'h0, 4'hD, 0);
    seg(2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst;
      raw = tbl[k].raw;
      sb.push_back(tbl[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({out_level, out_rise, out_fall, out_busy} !== {e.lvl, e.rise, e.fall, e.busy}) begin
        n_bad++;
        $display("FAIL vec%0d: got lvl=%h rise=%h fall=%h busy=%b, expected lvl=%h rise=%h fall=%h busy=%b",
                 k, out_level, out_rise, out_fall, out_busy, e.lvl, e.rise, e.fall, e.busy);
      end
    end

    // DEBOUNCE_CYCLES=1 instance: {level, rise, fall, busy} per cycle
    e1 = '{4'b0000, 4'b0000, 4'b0001, 4'b1100, 4'b1000,
           4'b1000, 4'b1000, 4'b1001, 4'b0010, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      raw1 = (i < 5);
      @(posedge clk); #1;
      check($sformatf("dc1_step%0d", i), {28'd0, lvl1, rise1, fall1, busy1}, {28'd0, e1[i]});
    end

`ifdef PMOD_DEBOUNCE_LONGPRESS_EN
    check("dc1_no_long", {31'd0, lng1}, 32'd0);
    raw = 4'h1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(posedge clk); #1;
      if (out_rise[0]) got = 1;
    end
    check("lp_rise_seen", got, 1);
    check("lp_long_at_rise", {31'd0, lng[0]}, 32'd0);
    at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (lng[0]) at = (at == 0) ? i : 99;
    end
    check("lp_long_delay", at, 8);
    raw = 4'h0;
    repeat (12) @(posedge clk);
    #1;
    check("lp_released", {28'd0, out_level}, 32'd0);
    raw = 4'h1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(posedge clk); #1;
      if (out_rise[0]) got = 1;
    end
    check("lp_short_rise_seen", got, 1);
    raw = 4'h0;
    at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (lng[0]) at = i;
    end
    check("lp_short_no_long", at, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pmod_debounce.md
Name: pmod_debounce

Overview:
Input-conditioning stage between the icestick PMOD header pins and the design core.
- Synchronises WIDTH asynchronous PMOD inputs into the in_clock domain.
- Debounces each input independently and emits a clean level per channel.
- Emits one-cycle rise and fall strobes per channel.
- The core consumes these outputs, e.g. the debounced level of the reset pin drives the core's in_reset and the strobes drive control events.

Parameters:
- WIDTH, 4: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flop depth; legal range 2..4.
- DEBOUNCE_CYCLES, 60000: consecutive differing cycles needed to accept a new level (5 ms at 12 MHz); legal range 1..2^24.
- INIT_LEVEL, 0: reset value of every synchroniser flop and of out_level.

Ports:
- in_clock, input, 1: sole clock; all flops on its rising edge.
- in_reset, input, 1: synchronous, active-high reset.
- in_raw, input, WIDTH: raw asynchronous PMOD pins.
- out_level, output, WIDTH: debounced, registered level per channel.
- out_rise, output, WIDTH: one-cycle strobe when out_level goes 0->1.
- out_fall, output, WIDTH: one-cycle strobe when out_level goes 1->0.
- out_busy, output, 1: OR over all channels of state == PENDING.

Behaviour:
- Reset (in_reset sampled high on an edge):
  - synchroniser flops = INIT_LEVEL; out_level = INIT_LEVEL.
  - out_rise, out_fall = 0; all counters = 0; all channels in STABLE; out_busy = 0.
  - Reset wins over every other event in the same cycle.
- Synchroniser: per channel, a chain of SYNC_STAGES flops. sync[i] is the last stage. No logic between stages.
- Counter: per channel, width $clog2(DEBOUNCE_CYCLES+1), saturating, never wraps.
- Channel FSM, two states:
  - STABLE:
    - sync == out_level: hold, cnt = 0.
    - sync != out_level: go to PENDING, cnt = 1.
  - PENDING:
    - sync == out_level: bounce; return to STABLE, cnt = 0, no strobe.
    - sync != out_level and cnt == DEBOUNCE_CYCLES: out_level <= sync; strobe out_rise or out_fall for exactly one cycle, registered and coincident with the out_level change; return to STABLE; cnt = 0.
    - otherwise: cnt <= cnt + 1.
- DEBOUNCE_CYCLES = 1: the level is accepted on the cycle after entering PENDING.
- Latency: a clean step on in_raw, sampled at edge E, changes out_level at edge E + SYNC_STAGES + DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync never changes out_level.
- Channels are fully independent; simultaneous strobes on several channels are legal.
- out_rise and out_fall for the same channel are never both high.
- Reset mid-PENDING abandons the count. No strobe is emitted, including when the input already differs from INIT_LEVEL.
- After reset release with in_raw != INIT_LEVEL held steady, the normal latency applies from the first post-reset edge.
- out_busy is registered, derived from next-state.

Optional Feature:
- Macro: PMOD_DEBOUNCE_LONGPRESS_EN.
- Defined:
  - adds parameter LONG_CYCLES, default 12000000 (1 s at 12 MHz);
  - adds output out_long, WIDTH: one-cycle strobe when out_level has been 1 for LONG_CYCLES consecutive cycles since its rise;
  - one strobe per press; a fall clears the hold counter; the hold counter saturates;
  - reset clears the hold counter and out_long.
- Undefined: port, parameter and hold counters are absent; all other behaviour is identical.

Decomposition:
- Package pmod_debounce_pkg:
  - state encoding localparams ST_STABLE = 1'b0, ST_PENDING = 1'b1;
  - default timing constants CLK_HZ = 12000000, DEBOUNCE_MS = 5;
  - a clog2 helper function.
- Sub-module pmod_debounce_chan: one channel's synchroniser, counter, FSM, strobes and optional hold counter. The top generates WIDTH instances and ORs the busy bits.

Test Plan (sim parameters WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: hold in_reset 3 cycles with in_raw=4'hF -> out_level=0, no strobes, out_busy=0. After release, out_level=4'hF at edge 2+4=6 after release, with out_rise=4'hF for 1 cycle.
- Clean step: ch0 0->1 at edge 10 -> out_level[0]=1 and out_rise[0]=1 at edge 16 only; out_fall stays 0.
- Bounce: ch1 toggled high for 3 cycles then low -> out_level[1] stays 0, no strobes, out_busy high then low.
- Bounce then settle: ch2 high 2 cycles, low 1, high steady -> accepted 4 cycles after the final rise reaches sync; exactly one out_rise[2].
- Reset mid-PENDING: ch3 stepping high, in_reset asserted when cnt=3 -> no strobe; out_level[3]=0; cnt restarts after release.
- With PMOD_DEBOUNCE_LONGPRESS_EN and LONG_CYCLES=8: ch0 held high -> out_long[0] pulses once 8 cycles after out_rise[0]. A release at 7 cycles -> no pulse.
